sumres_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit add/subtract datapath between up to eight requesters, such as the voice, envelope and pitch-offset channels of the synthesizer. Each accepted request latches its operands, runs a single add or subtract through the shared adder, and returns a registered result tagged with the requester's index. The block sits between the per-channel control logic and the adder.

---
 rtl/sumres_arb.sv | 111 +++++++++++
 tb/tb_sumres_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumres_arb.sv
// Round-robin arbiter sharing one 8-bit add/subtract datapath between NREQ requesters.
// A grant captures the winner's operands; the registered result follows one cycle later.
module sumres_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] op_a,
    input  logic [8*NREQ-1:0] op_b,
    input  logic [NREQ-1:0]   op_sub,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic [IDW-1:0]    done_id,
    output logic [7:0]        res,
    output logic              sig,
    output logic              ovf,
    output logic              dbg_state
);

    // Handshake: a requester holds req, operands and op_sub stable until it sees
    // its gnt pulse; the grant edge is the capture point. A req still set after
    // that is a fresh request and competes again at the next arbitration.

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] win_next;
    logic           win_ok;
    logic [7:0]     a_q;
    logic [7:0]     b_q;
    logic           sub_q;
    logic [IDW-1:0] id_q;
    logic [7:0]     bb;
    logic [8:0]     sum;
    int             j;

    assign dbg_state = logic'(state);

    // Scan from ptr upward with wrap; the first set bit wins.
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!win_ok && req[j]) begin
                win_ok = 1'b1;
                win    = IDW'(j);
            end
        end
    end

    assign win_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

    // Subtract is A + ~B + 1, so the carry-out is the inverse of the borrow.
    assign bb  = sub_q ? ~b_q : b_q;
    assign sum = {1'b0, a_q} + {1'b0, bb} + {8'd0, sub_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            res     <= '0;
            sig     <= 1'b0;
            ovf     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    gnt  <= '0;
                    if (win_ok) begin
                        a_q      <= op_a[8*win +: 8];
                        b_q      <= op_b[8*win +: 8];
                        sub_q    <= op_sub[win];
                        id_q     <= win;
                        gnt[win] <= 1'b1;
                        ptr      <= win_next;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    gnt     <= '0;
                    res     <= sum[7:0];
                    sig     <= sub_q ? ~sum[8] : sum[8];
                    ovf     <= (a_q[7] == bb[7]) && (sum[7] != a_q[7]);
                    done_id <= id_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sumres_arb.sv
// Bench for sumres_arb: directed scenarios plus a randomized run against a
// cycle-level reference model and an expected-result queue.
module tb_sumres_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] op_a = '0;
    logic [8*NREQ-1:0] op_b = '0;
    logic [NREQ-1:0]   op_sub = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic [7:0]        res;
    logic              sig;
    logic              ovf;
    logic              dbg_state;

    int total = 0;
    int bad   = 0;

    sumres_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .res(res),
        .sig(sig), .ovf(ovf), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int              m_ptr = 0;
    bit              m_busy = 0;
    logic [NREQ-1:0] exp_gnt = '0;
    logic            exp_busy = 0, exp_done = 0, exp_sig = 0, exp_ovf = 0;
    logic [7:0]      exp_res = '0;
    logic [IDW-1:0]  exp_id = '0;
    logic [7:0]      m_a, m_b;
    logic            m_sub;
    logic [IDW-1:0]  m_id;
    logic [IDW+9:0]  exp_q[$];

    // {ovf, sig, res} from plain integer arithmetic
    function automatic logic [9:0] calc(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        if (s) begin
            r = ua - ub; c = (ua < ub); sr = sa - sb;
        end else begin
            r = ua + ub; c = (r > 255); sr = sa + sb;
        end
        v = (sr > 127) || (sr < -128);
        return {v, c, 8'(r)};
    endfunction

    function automatic int pick(input logic [NREQ-1:0] rq, input int p);
        for (int k = 0; k < NREQ; k++)
            if (rq[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Advance the model with the inputs currently driven, then one clock.
    task automatic tick();
        int w;
        if (rst) begin
            m_ptr = 0; m_busy = 0; exp_gnt = '0; exp_busy = 0; exp_done = 0;
            exp_res = '0; exp_sig = 0; exp_ovf = 0; exp_id = '0;
        end else if (!m_busy) begin
            exp_done = 0;
            exp_gnt  = '0;
            w = pick(req, m_ptr);
            if (w >= 0) begin
                exp_gnt[w] = 1'b1;
                m_a   = op_a[8*w +: 8];
                m_b   = op_b[8*w +: 8];
                m_sub = op_sub[w];
                m_id  = IDW'(w);
                m_ptr = (w + 1) % NREQ;
                m_busy = 1;
                exp_busy = 1;
            end
        end else begin
            {exp_ovf, exp_sig, exp_res} = calc(m_a, m_b, m_sub);
            exp_id   = m_id;
            exp_done = 1;
            exp_gnt  = '0;
            exp_busy = 0;
            m_busy   = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            req = NREQ'($urandom); op_a = 32'($urandom); op_b = 32'($urandom); op_sub = NREQ'($urandom);
            tick();
            total++;
            if ({gnt, busy, done, done_id, res, sig, ovf, dbg_state} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b id=%0d res=%h sig=%b ovf=%b want all 0",
                         gnt, busy, done, done_id, res, sig, ovf);
            end
        end
        rst = 1'b0; req = '0;
        tick();
        total++;
        if (gnt !== '0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got gnt=%b done=%b want 0 0", gnt, done);
        end
    endtask

    task automatic test_single_add();
        req = 4'b0001; op_a[7:0] = 8'h7F; op_b[7:0] = 8'h01; op_sub[0] = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL add_gnt: got gnt=%b busy=%b want 0001 1", gnt, busy);
        end
        req = '0;
        tick();
        total++;
        if (done !== 1'b1 || res !== 8'h80 || sig !== 1'b0 || ovf !== 1'b1 || done_id !== 2'd0) begin
            bad++;
            $display("FAIL add_result: got done=%b res=%h sig=%b ovf=%b id=%0d want 1 80 0 1 0",
                     done, res, sig, ovf, done_id);
        end
    endtask

    task automatic test_sub_borrow();
        req = 4'b0010; op_a[15:8] = 8'h05; op_b[15:8] = 8'h07; op_sub[1] = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL sub_gnt: got %b want 0010", gnt);
        end
        req = '0;
        tick();
        total++;
        if (done !== 1'b1 || res !== 8'hFE || sig !== 1'b1 || ovf !== 1'b0 || done_id !== 2'd1) begin
            bad++;
            $display("FAIL sub_result: got done=%b res=%h sig=%b ovf=%b id=%0d want 1 fe 1 0 1",
                     done, res, sig, ovf, done_id);
        end
    endtask

    task automatic test_all_requesters();
        int order[4];
        int at[4];
        int n = 0;
        int cyc = 0;
        do_reset();
        req = '1; op_a = 32'($urandom); op_b = 32'($urandom); op_sub = NREQ'($urandom);
        while (n < 4 && cyc < 20) begin
            tick();
            cyc++;
            if (done) begin
                total++;
                if (res !== exp_res || sig !== exp_sig || ovf !== exp_ovf || done_id !== exp_id) begin
                    bad++;
                    $display("FAIL all_result: got id=%0d res=%h sig=%b ovf=%b want id=%0d res=%h sig=%b ovf=%b",
                             done_id, res, sig, ovf, exp_id, exp_res, exp_sig, exp_ovf);
                end
            end
            if (gnt != '0) begin
                order[n] = pick(gnt, 0);
                at[n] = cyc;
                n++;
                req = req & ~gnt;
            end
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL all_timeout: got %0d grants want 4", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (order[i] != i || at[i] != 2*i + 1) begin
                bad++;
                $display("FAIL all_order[%0d]: got id=%0d cyc=%0d want id=%0d cyc=%0d", i, order[i], at[i], i, 2*i + 1);
            end
        end
        req = '0;
        tick();
        // pointer back at 0: scanning 1010 from 0 must pick requester 1
        req = 4'b1010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL all_ptr_wrap: got %b want 0010", gnt);
        end
        req = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] want[4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        int n = 0;
        int cyc = 0;
        do_reset();
        req = 4'b0101;
        while (n < 4 && cyc < 20) begin
            tick();
            cyc++;
            if (gnt != '0) begin
                total++;
                if (gnt !== want[n]) begin
                    bad++;
                    $display("FAIL fair_grant[%0d]: got %b want %b", n, gnt, want[n]);
                end
                n++;
            end
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL fair_timeout: got %0d grants want 4", n);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_exec();
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL rexec_gnt: got %b want 0010", gnt);
        end
        rst = 1'b1; req = '0;
        tick();
        total++;
        if ({gnt, busy, done, done_id, res, sig, ovf} !== '0) begin
            bad++;
            $display("FAIL rexec_discard: got gnt=%b busy=%b done=%b res=%h want all 0", gnt, busy, done, res);
        end
        rst = 1'b0; req = 4'b0100; op_a[23:16] = 8'h80; op_b[23:16] = 8'h80; op_sub[2] = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL rexec_regrant: got %b want 0100", gnt);
        end
        req = '0;
        tick();
        total++;
        if (done !== 1'b1 || done_id !== 2'd2 || res !== 8'h00 || sig !== 1'b1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL rexec_result: got done=%b id=%0d res=%h sig=%b ovf=%b want 1 2 00 1 1",
                     done, done_id, res, sig, ovf);
        end
    endtask

    task automatic test_random();
        int pend[NREQ];
        int waited[NREQ];
        int g;
        logic [IDW+9:0] e;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; waited[i] = 0; end
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 3) == 0) begin
                    pend[i] = $urandom_range(1, 3);
                    op_a[8*i +: 8] = 8'($urandom);
                    op_b[8*i +: 8] = 8'($urandom);
                    op_sub[i] = 1'($urandom);
                end
                req[i] = (pend[i] > 0);
            end
            tick();
            total++;
            if (gnt !== exp_gnt || busy !== exp_busy || done !== exp_done || dbg_state !== exp_busy) begin
                bad++;
                $display("FAIL rand_ctrl cyc %0d: got gnt=%b busy=%b done=%b st=%b want gnt=%b busy=%b done=%b",
                         c, gnt, busy, done, dbg_state, exp_gnt, exp_busy, exp_done);
            end
            total++;
            if (res !== exp_res || sig !== exp_sig || ovf !== exp_ovf || done_id !== exp_id) begin
                bad++;
                $display("FAIL rand_hold cyc %0d: got id=%0d res=%h sig=%b ovf=%b want id=%0d res=%h sig=%b ovf=%b",
                         c, done_id, res, sig, ovf, exp_id, exp_res, exp_sig, exp_ovf);
            end
            if (done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_sb cyc %0d: got done with empty queue want no done", c);
                end else begin
                    e = exp_q.pop_front();
                    if ({done_id, ovf, sig, res} !== e) begin
                        bad++;
                        $display("FAIL rand_sb cyc %0d: got %h want %h", c, {done_id, ovf, sig, res}, e);
                    end
                end
            end
            g = pick(gnt, 0);
            if (g >= 0) begin
                exp_q.push_back({IDW'(g), calc(op_a[8*g +: 8], op_b[8*g +: 8], op_sub[g])});
                for (int i = 0; i < NREQ; i++) begin
                    if (i == g) waited[i] = 0;
                    else if (req[i]) waited[i]++;
                    total++;
                    if (waited[i] >= NREQ) begin
                        bad++;
                        $display("FAIL rand_fair cyc %0d: requester %0d waited %0d want < %0d", c, i, waited[i], NREQ);
                    end
                end
                if (pend[g] > 0) pend[g]--;
                if (pend[g] > 0) begin
                    op_a[8*g +: 8] = 8'($urandom);
                    op_b[8*g +: 8] = 8'($urandom);
                    op_sub[g] = 1'($urandom);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_borrow();
        test_all_requesters();
        test_fairness();
        test_reset_exec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
